display_scan_driver: RTL
========================

Name: display_scan_driver

Overview:
- Sequential 4-digit seven-segment scanner placed directly downstream of the BCD calculator (sign, tens, units).
- Replaces the manual digit-select switch with automatic time-multiplexed refresh of AN0..AN3.
- Double-buffers the calculator result so that a new result appears only at a frame boundary (no tearing).
- Adds anode dead-time and leading-zero blanking.

Parameters:
- PRESCALE, 50000, clocks per digit slot (≥2); one slot = PRESCALE clk cycles.
- DEAD, 2, clocks at the start of each slot with all anodes off (0 ≤ DEAD < PRESCALE).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  one-cycle strobe; capture sign/tens/units into the shadow buffer.
- sign  in  1  1 = negative result.
- tens  in  4  BCD tens digit.
- units  in  4  BCD units digit.
- blank_lz  in  1  1 = blank tens when it is 0.
- seg  out  7  active-low segments, seg[6]=a … seg[0]=g.
- dp  out  1  active-low decimal point, held 1 (off).
- an  out  4  active-low anodes, an[0]=AN0 (rightmost) … an[3]=AN3.
- frame_done  out  1  one-cycle pulse when the slot-3 period ends.

Behaviour:
- Reset (async, immediate): prescaler=0, slot=0, shadow and display registers=0, pending=0, an=4'b1111, seg=7'b1111111, dp=1, frame_done=0.
- Prescaler counts 0..PRESCALE-1 and wraps. tick = (prescaler==PRESCALE-1).
- On tick, slot advances 0→1→2→3→0.
- Slot content:
  - slot 0: units on AN0.
  - slot 1: tens on AN1; blank if blank_lz=1 and tens==0.
  - slot 2: sign on AN2; '-' if sign=1, else blank.
  - slot 3: AN3, always blank (anode still driven, segments off).
- Anode enable: an bit for the current slot = 0 only when prescaler ≥ DEAD; otherwise an=4'b1111. seg is valid throughout the slot.
- Output registering: seg and an are registered, so they lag the combinational slot/prescaler state by 1 clk.
- Segment codes (a..g, active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - '-'=1111110, blank=1111111, 'E'=0110000 (any BCD value >9).
- Shadow buffer:
  - load=1 writes sign/tens/units to the shadow and sets pending.
  - A later load before the transfer overwrites the shadow; last value wins.
- Transfer: on tick with slot==3 and pending=1, shadow → display registers and pending clears.
  - Same-cycle load and transfer: the transfer uses the old shadow; the new value is captured and pending stays 1.
- frame_done = 1 for exactly the cycle after the slot-3 tick (registered); asserted whether or not a transfer occurred.
- Reset mid-frame: everything returns to reset values asynchronously; scanning restarts at slot 0 with the display showing units 0 only (AN0 → 0, tens blanked if blank_lz, else 0).

Decomposition:
- Package display_pkg:
  - SEG_BLANK, SEG_DASH, SEG_E constants.
  - Slot index type (2-bit), with SLOT_UNITS=0, SLOT_TENS=1, SLOT_SIGN=2, SLOT_SPARE=3.
- Sub-module bcd_to_seg: combinational, 4-bit BCD in → 7-bit active-low pattern, 'E' for >9.
- Top: prescaler, slot counter, shadow/display registers, slot mux, output registers.

Test Plan (PRESCALE=4, DEAD=1 unless noted):
- Reset release, no load → an cycles 1110,1101,1011,0111 with one all-off clock at each slot start; seg = 0000001 in slot 0 and slot 1 (blank_lz=0).
- load with sign=1, tens=4, units=2 during slot 1 → display unchanged until the slot-3 tick; next frame shows AN0=0010010, AN1=1001100, AN2=1111110, AN3 blank; frame_done pulses once per 16 clks.
- blank_lz=1, tens=0, units=7, sign=0 → AN1 and AN2 seg=1111111, AN0=0001111.
- units=4'hC loaded → AN0 shows 0110000 ('E').
- Two loads in one frame (first 3/5, then 9/1) → only 9/1 is ever displayed; a load on the exact transfer cycle appears one frame later.
- rst asserted mid-slot 2 → an=1111 and seg=1111111 in the same cycle without a clock edge; after release, slot 0 is the first lit after DEAD clocks.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and segment constants for the seven-segment scan driver.
package display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_E     = 7'b0110000;

    typedef enum logic [1:0] {
        SLOT_UNITS = 2'd0,
        SLOT_TENS  = 2'd1,
        SLOT_SIGN  = 2'd2,
        SLOT_SPARE = 2'd3
    } slot_t;

    // One calculator result as held in the shadow and display buffers.
    typedef struct packed {
        logic       sign;
        logic [3:0] tens;
        logic [3:0] units;
    } digits_t;

endpackage

// File: rtl/display_scan_driver_if.sv
// Calculator-facing inputs and display-facing outputs of the scan driver.
interface display_scan_driver_if;

    logic       load;
    logic       sign;
    logic [3:0] tens;
    logic [3:0] units;
    logic       blank_lz;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_done;

    modport master (
        output load, sign, tens, units, blank_lz,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  load, sign, tens, units, blank_lz,
        output seg, dp, an, frame_done
    );

endinterface

// File: rtl/display_scan_driver_bcd_to_seg.sv
// BCD digit to active-low a..g segment pattern; any value above 9 shows 'E'.
module bcd_to_seg
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_E;
        case (bcd)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = SEG_E;
        endcase
    end

endmodule

// File: rtl/display_scan_driver.sv
// Four-digit time-multiplexed seven-segment scanner with a frame-synchronous
// double buffer, anode dead-time and leading-zero blanking.
module display_scan_driver
    import display_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int DEAD     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    display_scan_driver_if.slave  bus
);

    localparam int             PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]  DEAD_CNT  = PW'(DEAD);

    logic [PW-1:0] presc_q, presc_d;
    slot_t         slot_q, slot_d;
    digits_t       shadow_q, shadow_d;
    digits_t       disp_q, disp_d;
    logic          pending_q, pending_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          frame_done_q, frame_done_d;

    logic          tick;
    logic          frame_end;
    logic [3:0]    digit;
    logic [6:0]    digit_seg;

    assign tick      = (presc_q == PRESC_MAX);
    assign frame_end = tick && (slot_q == SLOT_SPARE);
    assign digit     = (slot_q == SLOT_TENS) ? disp_q.tens : disp_q.units;

    bcd_to_seg u_bcd_to_seg (
        .bcd (digit),
        .seg (digit_seg)
    );

    always_comb begin
        presc_d      = tick ? '0 : presc_q + 1'b1;
        slot_d       = tick ? slot_t'(slot_q + 2'd1) : slot_q;
        shadow_d     = shadow_q;
        disp_d       = disp_q;
        pending_d    = pending_q;
        frame_done_d = frame_end;

        // Transfer takes the old shadow; a same-cycle load re-arms pending.
        if (frame_end && pending_q) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
        end
        if (bus.load) begin
            shadow_d  = '{sign: bus.sign, tens: bus.tens, units: bus.units};
            pending_d = 1'b1;
        end

        seg_d = SEG_BLANK;
        case (slot_q)
            SLOT_UNITS: seg_d = digit_seg;
            SLOT_TENS:  seg_d = (bus.blank_lz && disp_q.tens == 4'd0) ? SEG_BLANK : digit_seg;
            SLOT_SIGN:  seg_d = disp_q.sign ? SEG_DASH : SEG_BLANK;
            SLOT_SPARE: seg_d = SEG_BLANK;
            default:    seg_d = SEG_BLANK;
        endcase

        // Anodes stay dark for the first DEAD clocks of each slot to avoid ghosting.
        an_d = 4'b1111;
        if (presc_q >= DEAD_CNT) begin
            case (slot_q)
                SLOT_UNITS: an_d = 4'b1110;
                SLOT_TENS:  an_d = 4'b1101;
                SLOT_SIGN:  an_d = 4'b1011;
                SLOT_SPARE: an_d = 4'b0111;
                default:    an_d = 4'b1111;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q      <= '0;
            slot_q       <= SLOT_UNITS;
            shadow_q     <= '0;
            disp_q       <= '0;
            pending_q    <= 1'b0;
            seg_q        <= SEG_BLANK;
            an_q         <= 4'b1111;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            slot_q       <= slot_d;
            shadow_q     <= shadow_d;
            disp_q       <= disp_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.dp         = 1'b1;
    assign bus.frame_done = frame_done_q;

endmodule
